// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: controller
// state encodings and the iteration counter sizing helper.
package seq_divider_pkg;

  // Controller states; the unused encoding 2'd3 is treated as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divState_e;

  // Iteration counter width: wide enough to hold WIDTH itself.
  function automatic int cntWidth(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_div_sub_stage.sv
// Trial subtract stage of the restoring divider: a WIDTH+1-bit ripple
// chain of full-adder cells computing minuend + ~subtrahend + 1.
// Only the low WIDTH difference bits are handed back. The carry out of
// the top cell is the "no borrow" flag, so nonNeg_o=1 means minuend >= subtrahend.
module div_sub_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   minuend_i,
  input  logic [WIDTH:0]   subtrahend_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             nonNeg_o
);

  logic carry;
  logic subBit;

  // Ripple the full-adder cells from LSB upward with carry-in of one.
  always_comb begin
    diff_o   = '0;
    carry    = 1'b1;
    subBit   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      subBit    = ~subtrahend_i[i];
      diff_o[i] = minuend_i[i] ^ subBit ^ carry;
      carry     = (minuend_i[i] & subBit) | (minuend_i[i] & carry) | (subBit & carry);
    end
    subBit   = ~subtrahend_i[WIDTH];
    nonNeg_o = (minuend_i[WIDTH] & subBit) | (minuend_i[WIDTH] & carry) | (subBit & carry);
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential restoring divider. One trial subtract per clock
// over WIDTH iterations, with a start/busy/done handshake. Divide by
// zero short-circuits straight to DONE with quotient all ones.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             dz_o
);

  localparam int CntW = cntWidth(WIDTH);

  divState_e       state_q, state_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   trialMinuend;
  logic [WIDTH:0]   trialSubtrahend;
  logic [WIDTH-1:0] trialDiff;
  logic             trialNonNeg;
  logic [WIDTH-1:0] shiftedRem;

  // The quotient register doubles as the dividend shifter: its MSB is
  // the next bit pulled down into the partial remainder.
  assign shiftedRem      = {remainder_q[WIDTH-2:0], quotient_q[WIDTH-1]};
  assign trialMinuend    = {remainder_q, quotient_q[WIDTH-1]};
  assign trialSubtrahend = {1'b0, divisor_q};

  div_sub_stage #(
    .WIDTH(WIDTH)
  ) uSubStage (
    .minuend_i   (trialMinuend),
    .subtrahend_i(trialSubtrahend),
    .diff_o      (trialDiff),
    .nonNeg_o    (trialNonNeg)
  );

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      quotient_q  <= '0;
      remainder_q <= '0;
      divisor_q   <= '0;
      count_q     <= '0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divisor_q   <= divisor_d;
      count_q     <= count_d;
      dz_q        <= dz_d;
    end
  end

  // Next-state and datapath update: iterate in RUN, accept new work in IDLE/DONE.
  always_comb begin
    state_d     = state_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divisor_d   = divisor_q;
    count_d     = count_q;
    dz_d        = dz_q;
    case (state_q)
      RUN: begin
        remainder_d = trialNonNeg ? trialDiff : shiftedRem;
        quotient_d  = {quotient_q[WIDTH-2:0], trialNonNeg};
        count_d     = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      default: begin
        if (start_i) begin
          count_d = '0;
          if (divisor_i != '0) begin
            divisor_d   = divisor_i;
            quotient_d  = dividend_i;
            remainder_d = '0;
            dz_d        = 1'b0;
            state_d     = RUN;
          end else begin
            quotient_d  = '1;
            remainder_d = dividend_i;
            dz_d        = 1'b1;
            state_d     = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign dz_o        = dz_q;

endmodule
